multi_edge_detector: RTL and testbench

//  N-channel debounced edge detector; successor to the single-channel rising-edge FSM.
//  Per channel: level sampled only on update strobe, debounced over DEBOUNCE samples,

---
 rtl/multi_edge_detector_pkg.sv | 34 +++
 rtl/multi_edge_detector_edge_channel.sv | 70 +++++++
 rtl/multi_edge_detector.sv | 52 +++++
 tb/tb_multi_edge_detector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_detector_pkg.sv
// Shared types and constants for the multi-channel debounced edge detector.
package multi_edge_detector_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic {
    STEADY = 1'b0,
    SETTLE = 1'b1
  } chan_state_e;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Per-channel status bundle handed from a channel to the top.
  typedef struct packed {
    logic tick;
    logic edge_dir;
    logic stable;
  } chan_status_t;

  // True when the configured mode wants an edge that settles to new_level.
  function automatic logic edge_enabled(input logic [1:0] mode, input logic new_level);
    if (new_level == HIGH) begin
      return (mode == MODE_RISE) || (mode == MODE_BOTH);
    end
    return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/multi_edge_detector_edge_channel.sv
// One debounced channel: settle counter, stable level, registered tick and edge direction.
module edge_channel
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = 3,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         update,
  input  logic         level,
  input  logic [1:0]   mode,
  output chan_status_t status
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  chan_state_e      state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             stable_q, next_stable;
  logic             tick_q, next_tick;
  logic             dir_q, next_dir;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= STEADY;
      cnt      <= '0;
      stable_q <= RESET_LEVEL;
      tick_q   <= 1'b0;
      dir_q    <= LOW;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      stable_q <= next_stable;
      tick_q   <= next_tick;
      dir_q    <= next_dir;
    end
  end

  // Debounce decision; evaluated only on update strobes.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_stable = stable_q;
    next_tick   = 1'b0;
    next_dir    = dir_q;
    if (update) begin
      if (level == stable_q) begin
        next_state = STEADY;
        next_cnt   = '0;
      end else if (cnt == CNT_LAST) begin
        next_state  = STEADY;
        next_cnt    = '0;
        next_stable = level;
        if (edge_enabled(mode, level)) begin
          next_tick = 1'b1;
          next_dir  = level;
        end
      end else begin
        next_state = SETTLE;
        next_cnt   = cnt + CNT_W'(1);
      end
    end
  end

  assign status = '{tick: tick_q, edge_dir: dir_q, stable: stable_q};

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel debounced edge detector with sticky write-1-to-clear pending flags and irq.
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DEBOUNCE    = 3,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   edge_dir,
  output logic [CHANNELS-1:0]   stable,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  chan_status_t status [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .DEBOUNCE   (DEBOUNCE),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .update(update),
      .level (level[i]),
      .mode  (mode[2*i+1:2*i]),
      .status(status[i])
    );
    assign tick[i]     = status[i].tick;
    assign edge_dir[i] = status[i].edge_dir;
    assign stable[i]   = status[i].stable;
  end

  // A tick landing in the same cycle as a clear still sets the flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear) | tick;
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (CHANNELS=4, DEBOUNCE=3, RESET_LEVEL=1).
module tb_multi_edge_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       update;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] tick, edge_dir, stable, pending;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  multi_edge_detector #(
    .CHANNELS   (4),
    .DEBOUNCE   (3),
    .RESET_LEVEL(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .update  (update),
    .level   (level),
    .mode    (mode),
    .clear   (clear),
    .tick    (tick),
    .edge_dir(edge_dir),
    .stable  (stable),
    .pending (pending),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One update strobe with the given levels; returns at the following negedge.
  task automatic upd(input logic [3:0] lv);
    level  = lv;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear(input logic [3:0] c);
    clear = c;
    @(negedge clk);
    clear = 4'b0000;
  endtask

  initial begin
    reset  = 1'b0;
    update = 1'b1;
    level  = 4'b0000;
    mode   = 8'b10_11_11_01;
    clear  = 4'b1111;

    // 1: reset dominates update/clear
    repeat (3) @(negedge clk);
    check("rst_tick",    32'(tick),     32'h0);
    check("rst_pending", 32'(pending),  32'h0);
    check("rst_stable",  32'(stable),   32'hf);
    check("rst_dir",     32'(edge_dir), 32'h0);
    check("rst_irq",     32'(irq),      32'h0);
    update = 1'b0;
    clear  = 4'b0000;
    reset  = 1'b1;
    idle(1);

    // 2: ch0 rise-only: fall accepted silently, rise ticks once
    upd(4'b1110);
    upd(4'b1110);
    check("t2_fall_pre_stable", 32'(stable), 32'hf);
    upd(4'b1110);
    check("t2_fall_tick",   32'(tick),   32'h0);
    check("t2_fall_stable", 32'(stable), 32'he);
    upd(4'b1111);
    upd(4'b1111);
    check("t2_rise_early_tick", 32'(tick), 32'h0);
    upd(4'b1111);
    check("t2_rise_tick",   32'(tick),     32'h1);
    check("t2_rise_dir",    32'(edge_dir), 32'h1);
    check("t2_rise_stable", 32'(stable),   32'hf);
    idle(1);
    check("t2_tick_1clk", 32'(tick),    32'h0);
    check("t2_pending",   32'(pending), 32'h1);
    check("t2_irq",       32'(irq),     32'h1);
    do_clear(4'b0001);
    check("t2_cleared", 32'(pending), 32'h0);
    check("t2_irq_off", 32'(irq),     32'h0);

    // 3: short glitches on ch1 are discarded; update=0 holds everything
    upd(4'b1101);
    upd(4'b1101);
    upd(4'b1111);
    check("t3_glitch_tick",   32'(tick),   32'h0);
    upd(4'b1101);
    upd(4'b1101);
    check("t3_restart_stable", 32'(stable), 32'hf);
    level = 4'b1101;
    idle(5);
    check("t3_noupd_stable", 32'(stable), 32'hf);
    check("t3_noupd_tick",   32'(tick),   32'h0);
    upd(4'b1111);
    check("t3_glitch_stable", 32'(stable),  32'hf);
    check("t3_pending",       32'(pending), 32'h0);

    // 4: ch2 in both mode, then off
    upd(4'b1011);
    upd(4'b1011);
    upd(4'b1011);
    check("t4_fall_tick", 32'(tick),     32'h4);
    check("t4_fall_dir",  32'(edge_dir), 32'h1);
    idle(1);
    upd(4'b1111);
    upd(4'b1111);
    upd(4'b1111);
    check("t4_rise_tick", 32'(tick),     32'h4);
    check("t4_rise_dir",  32'(edge_dir), 32'h5);
    idle(1);
    check("t4_pending", 32'(pending), 32'h4);
    mode = 8'b10_00_11_01;
    repeat (3) upd(4'b1011);
    check("t4_off_fall_tick",   32'(tick),   32'h0);
    check("t4_off_fall_stable", 32'(stable), 32'hb);
    repeat (3) upd(4'b1111);
    check("t4_off_rise_tick",   32'(tick),     32'h0);
    check("t4_off_rise_stable", 32'(stable),   32'hf);
    check("t4_off_dir",         32'(edge_dir), 32'h5);
    idle(1);
    check("t4_off_pending", 32'(pending), 32'h4);
    do_clear(4'b0100);
    mode = 8'b10_11_11_01;

    // 4b: simultaneous edges on all channels with mixed modes
    repeat (3) upd(4'b0000);
    check("t4b_fall_tick", 32'(tick),     32'he);
    check("t4b_fall_dir",  32'(edge_dir), 32'h1);
    repeat (3) upd(4'b1111);
    check("t4b_rise_tick", 32'(tick),     32'h7);
    check("t4b_rise_dir",  32'(edge_dir), 32'h7);
    idle(1);
    check("t4b_pending", 32'(pending), 32'hf);
    do_clear(4'b1111);
    check("t4b_cleared", 32'(pending), 32'h0);

    // 5: clear in the tick cycle loses to the set
    repeat (3) upd(4'b1110);
    repeat (3) upd(4'b1111);
    check("t5_tick", 32'(tick), 32'h1);
    do_clear(4'b0001);
    check("t5_race_pending", 32'(pending), 32'h1);
    check("t5_race_irq",     32'(irq),     32'h1);
    do_clear(4'b0001);
    check("t5_clear_pending", 32'(pending), 32'h0);
    check("t5_clear_irq",     32'(irq),     32'h0);

    // 6: reset mid-settle discards the partial count
    upd(4'b1100);
    upd(4'b1100);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("t6_rst_tick",   32'(tick),   32'h0);
    check("t6_rst_stable", 32'(stable), 32'hf);
    upd(4'b1100);
    check("t6_one_tick",   32'(tick),   32'h0);
    check("t6_one_stable", 32'(stable), 32'hf);
    upd(4'b1100);
    check("t6_two_stable", 32'(stable), 32'hf);
    upd(4'b1100);
    check("t6_full_tick",   32'(tick),     32'h2);
    check("t6_full_dir",    32'(edge_dir), 32'h0);
    check("t6_full_stable", 32'(stable),   32'hc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
